// File: rtl/ins_loader_if.sv
// Stream, program-memory write and status signals of the program loader.
// The loader sits on the slave side; the stimulus source/monitor uses master.
interface ins_loader_if #(
   parameter int unsigned AW = 6
);
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic [4:0]    in_opcode;
   logic [7:0]    in_operand;
   logic          in_last;
   logic          pm_we;
   logic [AW-1:0] pm_addr;
   logic [12:0]   pm_wdata;
   logic          cpu_hold;
   logic          done;
   logic          err;
   logic [1:0]    err_code;
   logic [AW:0]   words;

   modport slave (
      input  start, in_valid, in_opcode, in_operand, in_last,
      output in_ready, pm_we, pm_addr, pm_wdata, cpu_hold, done, err, err_code, words
   );

   modport master (
      output start, in_valid, in_opcode, in_operand, in_last,
      input  in_ready, pm_we, pm_addr, pm_wdata, cpu_hold, done, err, err_code, words
   );
endinterface

// File: rtl/ins_loader.sv
// Program-memory loader: validates opcode/operand pairs, packs them into 13-bit words and
// writes them from address 0 upward while holding the core in reset.
module ins_loader #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst,
   ins_loader_if.slave    bus
);

   localparam logic [1:0] SEC_R       = 2'b00;
   localparam logic [1:0] SEC_REST    = 2'b11;
   localparam logic [2:0] JMP         = 3'd7;
   localparam logic [4:0] OPCODE_ST_R = 5'b00101;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_OPERAND = 2'd1;
   localparam logic [1:0] ERR_OVFL    = 2'd2;

   typedef enum logic [2:0] {StIdle, StAccept, StWrite, StDone, StErr} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [12:0]   word_q, word_d;
   logic          last_q, last_d;
   logic [AW:0]   words_q, words_d;
   logic [1:0]    err_code_q, err_code_d;

   logic [1:0] sec;
   logic [2:0] rest;
   logic       op_ok;
   logic       hs;
   logic       at_top;

   assign sec    = bus.in_opcode[4:3];
   assign rest   = bus.in_opcode[2:0];
   assign hs     = bus.in_valid & (state_q == StAccept);
   assign at_top = (ptr_q == AW'(DEPTH - 1));

   always_comb begin
      op_ok = 1'b1;
      if (sec == SEC_R && bus.in_opcode == OPCODE_ST_R && bus.in_operand[7:2] != 6'd0) begin
         op_ok = 1'b0;
      end
      if (sec != SEC_REST && rest == JMP && bus.in_operand[7:6] != 2'd0) begin
         op_ok = 1'b0;
      end
      // Rest codes 6 and 7 are unassigned in the last section.
      if (sec == SEC_REST && rest > 3'd5) begin
         op_ok = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.start) begin
         state_d = StAccept;
      end else begin
         unique case (state_q)
            StAccept: if (hs) state_d = op_ok ? StWrite : StErr;
            StWrite: begin
               if (last_q)      state_d = StDone;
               else if (at_top) state_d = StErr;
               else             state_d = StAccept;
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      bus.in_ready = (state_q == StAccept);
      bus.pm_we    = (state_q == StWrite);
      bus.cpu_hold = (state_q == StAccept) || (state_q == StWrite) || (state_q == StErr);
      bus.done     = (state_q == StDone);
      bus.err      = (state_q == StErr);
      bus.pm_addr  = ptr_q;
      bus.pm_wdata = word_q;
      bus.err_code = err_code_q;
      bus.words    = words_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q      <= '0;
         word_q     <= '0;
         last_q     <= 1'b0;
         words_q    <= '0;
         err_code_q <= ERR_NONE;
      end else begin
         ptr_q      <= ptr_d;
         word_q     <= word_d;
         last_q     <= last_d;
         words_q    <= words_d;
         err_code_q <= err_code_d;
      end
   end

   // A restart discards the word being written that cycle: its pulse still goes out,
   // but neither the pointer nor the word count advance for it.
   always_comb begin
      ptr_d      = ptr_q;
      word_d     = word_q;
      last_d     = last_q;
      words_d    = words_q;
      err_code_d = err_code_q;
      if (bus.start) begin
         ptr_d      = '0;
         words_d    = '0;
         err_code_d = ERR_NONE;
      end else if (state_q == StAccept && hs) begin
         if (op_ok) begin
            word_d = {bus.in_opcode, bus.in_operand};
            last_d = bus.in_last;
         end else begin
            err_code_d = ERR_OPERAND;
         end
      end else if (state_q == StWrite) begin
         words_d = words_q + 1'b1;
         if (!at_top) ptr_d = ptr_q + 1'b1;
         if (!last_q && at_top) err_code_d = ERR_OVFL;
      end
   end

endmodule

// File: tb/tb_ins_loader.sv
// Self-checking bench for ins_loader: expected writes are queued as words are sent and
// compared when the loader pulses pm_we.
module tb_ins_loader;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned AW    = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ins_loader_if #(.AW(AW)) ifc ();

   ins_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int exp_addr = 0;
   logic [18:0] sb_q[$];
   logic prev_hs = 1'b0;
   logic prev_start = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Write monitor and accept-spacing check.
   always @(negedge clk) begin
      logic [18:0] e;
      if (ifc.pm_we) begin
         if (sb_q.size() == 0) begin
            check("unexpected_we", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("wr_addr", 32'(ifc.pm_addr), 32'(e[18:13]));
            check("wr_data", 32'(ifc.pm_wdata), 32'(e[12:0]));
         end
      end
      if (prev_hs && !prev_start) check("ready_drop", 32'(ifc.in_ready), 32'd0);
      prev_hs    = ifc.in_ready & ifc.in_valid;
      prev_start = ifc.start;
   end

   task automatic do_start();
      ifc.start = 1'b1;
      exp_addr  = 0;
      @(negedge clk);
      ifc.start = 1'b0;
   endtask

   // Called at a falling edge; returns at the falling edge after the handshake.
   task automatic send(input logic [4:0] op, input logic [7:0] opd, input logic last,
                       input bit push, input bit keep);
      int n = 0;
      ifc.in_valid   = 1'b1;
      ifc.in_opcode  = op;
      ifc.in_operand = opd;
      ifc.in_last    = last;
      while (!ifc.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ifc.in_ready) begin
         check("ready_timeout", 32'd0, 32'd1);
      end else if (push) begin
         sb_q.push_back({6'(exp_addr), op, opd});
         exp_addr++;
      end
      @(negedge clk);
      if (!keep) ifc.in_valid = 1'b0;
   endtask

   task automatic wait_end();
      int n = 0;
      while (!ifc.done && !ifc.err && n < 10) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      ifc.start      = 1'b0;
      ifc.in_valid   = 1'b0;
      ifc.in_opcode  = '0;
      ifc.in_operand = '0;
      ifc.in_last    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(ifc.in_ready), 32'd0);
      check("rst_hold", 32'(ifc.cpu_hold), 32'd0);
      check("rst_we", 32'(ifc.pm_we), 32'd0);
      check("rst_flags", {ifc.done, ifc.err, ifc.err_code}, 32'd0);
      check("rst_words", 32'(ifc.words), 32'd0);

      // Three-word program with valid held high throughout.
      do_start();
      check("ld_ready", 32'(ifc.in_ready), 32'd1);
      check("ld_hold", 32'(ifc.cpu_hold), 32'd1);
      send(5'b00000, 8'h02, 1'b0, 1'b1, 1'b1);
      send(5'b10000, 8'hA5, 1'b0, 1'b1, 1'b1);
      send(5'b00111, 8'h3F, 1'b1, 1'b1, 1'b0);
      wait_end();
      check("ld_words", 32'(ifc.words), 32'd3);
      check("ld_done", 32'(ifc.done), 32'd1);
      check("ld_hold_rel", 32'(ifc.cpu_hold), 32'd0);
      check("ld_err", 32'(ifc.err), 32'd0);

      // ST_R with an out-of-range register.
      do_start();
      send(5'b00101, 8'h04, 1'b0, 1'b0, 1'b0);
      wait_end();
      check("str_err", 32'(ifc.err), 32'd1);
      check("str_code", 32'(ifc.err_code), 32'd1);
      check("str_hold", 32'(ifc.cpu_hold), 32'd1);
      check("str_words", 32'(ifc.words), 32'd0);

      // Restart clears flags; JMP beyond 6 bits fails.
      do_start();
      check("rs_flags", {ifc.done, ifc.err, ifc.err_code}, 32'd0);
      check("rs_ready", 32'(ifc.in_ready), 32'd1);
      send(5'b01111, 8'h40, 1'b1, 1'b0, 1'b0);
      wait_end();
      check("jmp_code", 32'(ifc.err_code), 32'd1);
      check("jmp_done", 32'(ifc.done), 32'd0);

      // Illegal opcode in the last section.
      do_start();
      send(5'b11110, 8'h00, 1'b0, 1'b0, 1'b0);
      wait_end();
      check("ill_code", 32'(ifc.err_code), 32'd1);

      // Load resumes at address 0; start coinciding with a valid word wins.
      do_start();
      ifc.in_valid   = 1'b1;
      ifc.in_opcode  = 5'b10001;
      ifc.in_operand = 8'h11;
      ifc.in_last    = 1'b0;
      do_start();
      ifc.in_valid = 1'b0;
      check("sa_we", 32'(ifc.pm_we), 32'd0);
      check("sa_words", 32'(ifc.words), 32'd0);
      check("sa_ready", 32'(ifc.in_ready), 32'd1);
      send(5'b01000, 8'h7E, 1'b1, 1'b1, 1'b0);
      wait_end();
      check("sa_words1", 32'(ifc.words), 32'd1);
      check("sa_done", 32'(ifc.done), 32'd1);

      // Start during WRITE: the pulse completes but is not counted.
      do_start();
      send(5'b10010, 8'h33, 1'b0, 1'b1, 1'b0);
      do_start();
      check("sw_words", 32'(ifc.words), 32'd0);
      check("sw_addr", 32'(ifc.pm_addr), 32'd0);
      check("sw_ready", 32'(ifc.in_ready), 32'd1);

      // Overflow: DEPTH words without last.
      do_start();
      for (int i = 0; i < int'(DEPTH); i++) begin
         send(5'b10000, 8'(i * 3), 1'b0, 1'b1, i < int'(DEPTH) - 1);
      end
      wait_end();
      check("ov_err", 32'(ifc.err), 32'd1);
      check("ov_code", 32'(ifc.err_code), 32'd2);
      check("ov_words", 32'(ifc.words), 32'd64);
      repeat (3) @(negedge clk);
      check("ov_nowe", 32'(ifc.pm_we), 32'd0);

      // Asynchronous reset while writing the second word.
      do_start();
      send(5'b00001, 8'h01, 1'b0, 1'b1, 1'b0);
      ifc.in_valid   = 1'b1;
      ifc.in_opcode  = 5'b00010;
      ifc.in_operand = 8'h03;
      begin
         int n = 0;
         while (!ifc.in_ready && n < 10) begin
            @(negedge clk);
            n++;
         end
      end
      @(posedge clk);
      #2;
      check("ar_we_pre", 32'(ifc.pm_we), 32'd1);
      check("ar_addr_pre", 32'(ifc.pm_addr), 32'd1);
      rst = 1'b1;
      #1;
      check("ar_we", 32'(ifc.pm_we), 32'd0);
      check("ar_hold", 32'(ifc.cpu_hold), 32'd0);
      check("ar_addr", 32'(ifc.pm_addr), 32'd0);
      check("ar_words", 32'(ifc.words), 32'd0);
      ifc.in_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
